// File: rtl/fnn_ctrl_pkg.sv
// Shared types and default constants for the layer sequencer.
package fnn_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, FILL, FEED, WAIT, DRAIN} layer_state_t;

  localparam int unsigned DefDataWidth = 16;
  localparam int unsigned DefWaitLimit = 16;

endpackage

// File: rtl/fnn_layer_ctrl_if.sv
// Stream and neuron-broadcast signals around one layer sequencer.
// master: the surroundings (upstream, neurons, downstream); slave: the controller.
interface fnn_layer_ctrl_if
  import fnn_ctrl_pkg::*;
#(
  parameter int unsigned dataWidth  = DefDataWidth,
  parameter int unsigned numNeurons = 30
) ();

  logic [dataWidth-1:0]            in_data;
  logic                            in_valid;
  logic                            in_ready;
  logic [dataWidth-1:0]            nrn_input;
  logic                            nrn_input_valid;
  logic [numNeurons*dataWidth-1:0] nrn_out;
  logic [numNeurons-1:0]           nrn_outvalid;
  logic [dataWidth-1:0]            out_data;
  logic                            out_valid;
  logic                            out_ready;

  modport master (
    output in_data, in_valid, nrn_out, nrn_outvalid, out_ready,
    input  in_ready, nrn_input, nrn_input_valid, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, nrn_out, nrn_outvalid, out_ready,
    output in_ready, nrn_input, nrn_input_valid, out_data, out_valid
  );

endinterface

// File: rtl/fnn_vec_buf.sv
// Depth x Width register array: per-entry write enables, one combinational read port.
module fnn_vec_buf #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 16,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic                   clk,
  input  logic [Depth-1:0]       wr_en,
  input  logic [Depth*Width-1:0] wr_data,
  input  logic [AddrW-1:0]       rd_addr,
  output logic [Width-1:0]       rd_data
);

  logic [Width-1:0] mem [Depth];

  // Entries with their enable set take their own slice of wr_data.
  always_ff @(posedge clk) begin
    for (int i = 0; i < Depth; i++) begin
      if (wr_en[i]) mem[i] <= wr_data[i*Width +: Width];
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fnn_layer_ctrl.sv
// Buffers one input vector, broadcasts it gap-free to all neurons, collects
// every neuron result and streams the results out in neuron order.
module fnn_layer_ctrl
  import fnn_ctrl_pkg::*;
#(
  parameter int unsigned numInputs  = 30,
  parameter int unsigned numNeurons = 30,
  parameter int unsigned dataWidth  = DefDataWidth,
  parameter int unsigned waitLimit  = DefWaitLimit
) (
  input  logic             clk,
  input  logic             rst,
  fnn_layer_ctrl_if.slave  bus,
  output logic             busy,
  output logic             timeout_err
);

  localparam int unsigned InCntW   = $clog2(numInputs + 1);
  localparam int unsigned OutCntW  = $clog2(numNeurons + 1);
  localparam int unsigned WaitCntW = $clog2(waitLimit + 1);
  localparam int unsigned InAw     = (numInputs > 1) ? $clog2(numInputs) : 1;
  localparam int unsigned OutAw    = (numNeurons > 1) ? $clog2(numNeurons) : 1;

  layer_state_t          state_q, state_d;
  logic [InCntW-1:0]     in_cnt_q, in_cnt_d;
  logic [OutCntW-1:0]    out_idx_q, out_idx_d;
  logic [WaitCntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic [numNeurons-1:0] mask_q, mask_d;
  logic [dataWidth-1:0]  nrn_input_q, nrn_input_d;
  logic                  nrn_valid_q, nrn_valid_d;
  logic                  busy_q;
  logic                  timeout_q, timeout_d;

  logic                  in_hs;
  logic [numInputs-1:0]  in_we;
  logic [InAw-1:0]       in_raddr;
  logic [dataWidth-1:0]  in_rdata;
  logic [numNeurons-1:0] res_we;
  logic [dataWidth-1:0]  res_rdata;

  fnn_vec_buf #(
    .Depth (numInputs),
    .Width (dataWidth)
  ) u_in_buf (
    .clk     (clk),
    .wr_en   (in_we),
    .wr_data ({numInputs{bus.in_data}}),
    .rd_addr (in_raddr),
    .rd_data (in_rdata)
  );

  fnn_vec_buf #(
    .Depth (numNeurons),
    .Width (dataWidth)
  ) u_res_buf (
    .clk     (clk),
    .wr_en   (res_we),
    .wr_data (bus.nrn_out),
    .rd_addr (OutAw'(out_idx_q)),
    .rd_data (res_rdata)
  );

  // Held low during reset so a handshake coinciding with rst is never taken.
  assign bus.in_ready  = !rst && ((state_q == IDLE) || (state_q == FILL));
  assign in_hs         = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = (state_q == DRAIN) ? res_rdata : '0;

  assign bus.nrn_input       = nrn_input_q;
  assign bus.nrn_input_valid = nrn_valid_q;
  assign busy                = busy_q;
  assign timeout_err         = timeout_q;

  // Next-state, counters, buffer write enables and the next broadcast sample.
  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    out_idx_d   = out_idx_q;
    wait_cnt_d  = wait_cnt_q;
    mask_d      = mask_q;
    nrn_input_d = '0;
    nrn_valid_d = 1'b0;
    timeout_d   = timeout_q;
    in_we       = '0;
    in_raddr    = '0;
    res_we      = '0;

    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          in_we    = numInputs'(1);
          in_cnt_d = InCntW'(1);
          state_d  = FILL;
        end
      end
      FILL: begin
        if (in_hs) begin
          in_we = numInputs'(1) << in_cnt_q;
          if (in_cnt_q == InCntW'(numInputs - 1)) begin
            // Entry 0 is already stored, so the first broadcast is registered now.
            state_d     = FEED;
            in_cnt_d    = '0;
            in_raddr    = '0;
            nrn_input_d = in_rdata;
            nrn_valid_d = 1'b1;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      FEED: begin
        // in_cnt_q is the index currently on nrn_input; preload the next one.
        if (in_cnt_q == InCntW'(numInputs - 1)) begin
          state_d    = WAIT;
          in_cnt_d   = '0;
          mask_d     = '0;
          wait_cnt_d = '0;
        end else begin
          in_cnt_d    = in_cnt_q + 1'b1;
          in_raddr    = InAw'(in_cnt_q + 1'b1);
          nrn_input_d = in_rdata;
          nrn_valid_d = 1'b1;
        end
      end
      WAIT: begin
        res_we = bus.nrn_outvalid;
        mask_d = mask_q | bus.nrn_outvalid;
        if (&mask_d) begin
          state_d   = DRAIN;
          out_idx_d = '0;
        end else if (wait_cnt_q == WaitCntW'(waitLimit - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (bus.out_ready) begin
          if (out_idx_q == OutCntW'(numNeurons - 1)) begin
            state_d   = IDLE;
            out_idx_d = '0;
          end else begin
            out_idx_d = out_idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      in_cnt_q    <= '0;
      out_idx_q   <= '0;
      wait_cnt_q  <= '0;
      mask_q      <= '0;
      nrn_input_q <= '0;
      nrn_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      out_idx_q   <= out_idx_d;
      wait_cnt_q  <= wait_cnt_d;
      mask_q      <= mask_d;
      nrn_input_q <= nrn_input_d;
      nrn_valid_q <= nrn_valid_d;
      busy_q      <= (state_d != IDLE);
      timeout_q   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_fnn_layer_ctrl.sv
// Directed bench for fnn_layer_ctrl with numInputs=4, numNeurons=3.
module tb_fnn_layer_ctrl;
  import fnn_ctrl_pkg::*;

  localparam int unsigned NIn  = 4;
  localparam int unsigned NNrn = 3;
  localparam int unsigned DW   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic timeout_err;

  int tests_run    = 0;
  int tests_failed = 0;

  fnn_layer_ctrl_if #(.dataWidth(DW), .numNeurons(NNrn)) bus ();

  fnn_layer_ctrl #(
    .numInputs  (NIn),
    .numNeurons (NNrn),
    .dataWidth  (DW),
    .waitLimit  (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives four consecutive samples starting at 'first'; returns in the cycle
  // after the last handshake.
  task automatic send_vec(input logic [15:0] first, input bit gapped);
    for (int i = 0; i < 4; i++) begin
      bus.in_data  = first + 16'(i);
      bus.in_valid = 1'b1;
      step();
      if (gapped && i < 3) begin
        bus.in_valid = 1'b0;
        step();
      end
    end
    bus.in_valid = 1'b0;
  endtask

  // From the first WAIT cycle: all neurons respond at once, results drained.
  task automatic capture_and_drain();
    bus.nrn_out      = {16'h0030, 16'h0020, 16'h0010};
    bus.nrn_outvalid = 3'b111;
    step();
    bus.nrn_outvalid = 3'b000;
    bus.out_ready    = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    repeat (2) step();
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_in_ready_low: got %b want 0", bus.in_ready);
    end
    tests_run++;
    if ({bus.nrn_input_valid, bus.nrn_input} !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_nrn_input: got %b/%h want 0/0000", bus.nrn_input_valid, bus.nrn_input);
    end
    tests_run++;
    if ({bus.out_valid, bus.out_data} !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_out: got %b/%h want 0/0000", bus.out_valid, bus.out_data);
    end
    tests_run++;
    if ({busy, timeout_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_busy_err: got %b%b want 00", busy, timeout_err);
    end
    rst = 1'b0;
    step();
    tests_run++;
    if (bus.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL idle_in_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    logic [15:0] exp_res [3];
    exp_res[0] = 16'h0010; exp_res[1] = 16'h0020; exp_res[2] = 16'h0030;
    bus.out_ready = 1'b1;
    send_vec(16'd1, 1'b0);
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if ({bus.nrn_input_valid, bus.nrn_input} !== {1'b1, 16'(j + 1)}) begin
        tests_failed++;
        $display("FAIL basic_bcast%0d: got %b/%h want 1/%h", j, bus.nrn_input_valid,
                 bus.nrn_input, 16'(j + 1));
      end
      step();
    end
    tests_run++;
    if (bus.nrn_input_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_bcast_end: got %b want 0", bus.nrn_input_valid);
    end
    repeat (5) step();
    bus.nrn_out      = {16'h0030, 16'h0020, 16'h0010};
    bus.nrn_outvalid = 3'b111;
    step();
    bus.nrn_outvalid = 3'b000;
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if ({busy, bus.out_valid, bus.out_data} !== {2'b11, exp_res[j]}) begin
        tests_failed++;
        $display("FAIL basic_drain%0d: got busy=%b v=%b d=%h want 1/1/%h", j, busy,
                 bus.out_valid, bus.out_data, exp_res[j]);
      end
      step();
    end
    tests_run++;
    if ({busy, bus.out_valid, timeout_err} !== 3'b000) begin
      tests_failed++;
      $display("FAIL basic_done: got busy=%b v=%b err=%b want 0/0/0", busy, bus.out_valid,
               timeout_err);
    end
  endtask

  task automatic test_gapped();
    send_vec(16'h0101, 1'b1);
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if ({bus.nrn_input_valid, bus.nrn_input} !== {1'b1, 16'h0101 + 16'(j)}) begin
        tests_failed++;
        $display("FAIL gapped_bcast%0d: got %b/%h want 1/%h", j, bus.nrn_input_valid,
                 bus.nrn_input, 16'h0101 + 16'(j));
      end
      step();
    end
    tests_run++;
    if (bus.nrn_input_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL gapped_bcast_end: got %b want 0", bus.nrn_input_valid);
    end
    capture_and_drain();
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL gapped_done: busy got %b want 0", busy);
    end
  endtask

  task automatic test_staggered();
    logic [15:0] exp_res [3];
    exp_res[0] = 16'h0010; exp_res[1] = 16'h0020; exp_res[2] = 16'h0030;
    bus.out_ready = 1'b1;
    send_vec(16'd1, 1'b0);
    repeat (4) step();
    step();
    bus.nrn_out = {16'hbad2, 16'hbad1, 16'h0010};
    bus.nrn_outvalid = 3'b001;
    step();
    bus.nrn_outvalid = 3'b000;
    step();
    bus.nrn_out = {16'h0030, 16'hbad1, 16'hdead};
    bus.nrn_outvalid = 3'b100;
    step();
    bus.nrn_outvalid = 3'b000;
    step();
    bus.nrn_out = {16'heeee, 16'h0020, 16'hffff};
    bus.nrn_outvalid = 3'b010;
    tests_run++;
    if (bus.out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stagger_early_drain: out_valid got %b want 0", bus.out_valid);
    end
    step();
    bus.nrn_outvalid = 3'b000;
    bus.nrn_out = '0;
    for (int j = 0; j < 3; j++) begin
      tests_run++;
      if ({bus.out_valid, bus.out_data} !== {1'b1, exp_res[j]}) begin
        tests_failed++;
        $display("FAIL stagger_drain%0d: got %b/%h want 1/%h", j, bus.out_valid,
                 bus.out_data, exp_res[j]);
      end
      step();
    end
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL stagger_done: busy got %b want 0", busy);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b1;
    send_vec(16'd5, 1'b0);
    repeat (4) step();
    bus.nrn_out      = {16'h0030, 16'h0020, 16'h0010};
    bus.nrn_outvalid = 3'b111;
    step();
    bus.nrn_outvalid = 3'b000;
    tests_run++;
    if ({bus.out_valid, bus.out_data} !== 17'h1_0010) begin
      tests_failed++;
      $display("FAIL bp_first: got %b/%h want 1/0010", bus.out_valid, bus.out_data);
    end
    step();
    tests_run++;
    if ({bus.out_valid, bus.out_data} !== 17'h1_0020) begin
      tests_failed++;
      $display("FAIL bp_second: got %b/%h want 1/0020", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      tests_run++;
      if ({bus.out_valid, bus.out_data} !== 17'h1_0020) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got %b/%h want 1/0020", j, bus.out_valid, bus.out_data);
      end
    end
    bus.out_ready = 1'b1;
    step();
    tests_run++;
    if ({bus.out_valid, bus.out_data} !== 17'h1_0030) begin
      tests_failed++;
      $display("FAIL bp_third: got %b/%h want 1/0030", bus.out_valid, bus.out_data);
    end
    step();
    tests_run++;
    if ({busy, bus.out_valid} !== 2'b00) begin
      tests_failed++;
      $display("FAIL bp_done: got busy=%b v=%b want 0/0", busy, bus.out_valid);
    end
  endtask

  task automatic test_timeout();
    bit seen_valid = 1'b0;
    bus.out_ready = 1'b1;
    send_vec(16'd9, 1'b0);
    repeat (4) step();
    for (int i = 0; i < 15; i++) begin
      if (i == 5) begin
        bus.nrn_out      = {16'h0030, 16'h0020, 16'h0010};
        bus.nrn_outvalid = 3'b011;
      end else begin
        bus.nrn_outvalid = 3'b000;
      end
      if (bus.out_valid) seen_valid = 1'b1;
      step();
    end
    tests_run++;
    if ({busy, timeout_err} !== 2'b10) begin
      tests_failed++;
      $display("FAIL timeout_last_wait: got busy=%b err=%b want 1/0", busy, timeout_err);
    end
    step();
    if (bus.out_valid) seen_valid = 1'b1;
    tests_run++;
    if ({busy, timeout_err, bus.in_ready} !== 3'b011) begin
      tests_failed++;
      $display("FAIL timeout_idle: got busy=%b err=%b rdy=%b want 0/1/1", busy, timeout_err,
               bus.in_ready);
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_no_out: out_valid seen %b want 0", seen_valid);
    end
    send_vec(16'h0a00, 1'b0);
    tests_run++;
    if ({bus.nrn_input_valid, bus.nrn_input} !== 17'h1_0a00) begin
      tests_failed++;
      $display("FAIL timeout_next_bcast: got %b/%h want 1/0a00", bus.nrn_input_valid,
               bus.nrn_input);
    end
    repeat (4) step();
    bus.nrn_out      = {16'h0033, 16'h0022, 16'h0011};
    bus.nrn_outvalid = 3'b111;
    step();
    bus.nrn_outvalid = 3'b000;
    tests_run++;
    if ({bus.out_valid, bus.out_data, timeout_err} !== {1'b1, 16'h0011, 1'b1}) begin
      tests_failed++;
      $display("FAIL timeout_next_drain: got v=%b d=%h err=%b want 1/0011/1", bus.out_valid,
               bus.out_data, timeout_err);
    end
    repeat (3) step();
    tests_run++;
    if ({busy, timeout_err} !== 2'b01) begin
      tests_failed++;
      $display("FAIL timeout_sticky: got busy=%b err=%b want 0/1", busy, timeout_err);
    end
  endtask

  task automatic test_reset_mid_feed();
    bit seen_valid = 1'b0;
    send_vec(16'h0200, 1'b0);
    step();
    tests_run++;
    if ({bus.nrn_input_valid, bus.nrn_input} !== 17'h1_0201) begin
      tests_failed++;
      $display("FAIL rstfeed_second: got %b/%h want 1/0201", bus.nrn_input_valid,
               bus.nrn_input);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (bus.in_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstfeed_in_ready_rst: got %b want 0", bus.in_ready);
    end
    step();
    rst = 1'b0;
    #1;
    tests_run++;
    if ({bus.nrn_input_valid, busy, timeout_err, bus.in_ready} !== 4'b0001) begin
      tests_failed++;
      $display("FAIL rstfeed_after: got v=%b busy=%b err=%b rdy=%b want 0/0/0/1",
               bus.nrn_input_valid, busy, timeout_err, bus.in_ready);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.nrn_input_valid || busy) seen_valid = 1'b1;
    end
    tests_run++;
    if (seen_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstfeed_quiet: activity seen %b want 0", seen_valid);
    end
  endtask

  initial begin
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.nrn_out      = '0;
    bus.nrn_outvalid = '0;
    bus.out_ready    = 1'b0;
    test_reset();
    test_basic();
    test_gapped();
    test_staggered();
    test_backpressure();
    test_timeout();
    test_reset_mid_feed();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
